// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C memory sequencer: FSM encoding, byte-controller
// command payload and the default target slave address.
package i2c_seq_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ADR_W  = 7;

  localparam logic [ADR_W-1:0] SLAVE_ADR_DEF = 7'b001_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SADR_W,
    ST_MADR,
    ST_WDATA,
    ST_SADR_R,
    ST_RDATA,
    ST_STOP,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic              start;
    logic              stop;
    logic              read;
    logic              write;
    logic              ack_in;
    logic [BYTE_W-1:0] din;
  } bc_cmd_t;

  function automatic bc_cmd_t mk_cmd(input logic start, input logic stop,
                                     input logic read, input logic write,
                                     input logic ack_in,
                                     input logic [BYTE_W-1:0] din);
    bc_cmd_t c;
    c.start  = start;
    c.stop   = stop;
    c.read   = read;
    c.write  = write;
    c.ack_in = ack_in;
    c.din    = din;
    return c;
  endfunction

endpackage

// File: rtl/i2c_mem_seq.sv
// Sequences byte-controller commands for multi-byte I2C memory reads/writes
// (slave address, memory address, optional repeated start, data, stop).
module i2c_mem_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADR = SLAVE_ADR_DEF
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] mem_adr,
  input  logic [1:0] len,
  input  logic [7:0] wdat,
  output logic       wdat_take,
  output logic [7:0] rdat,
  output logic       rdat_vld,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       bc_start,
  output logic       bc_stop,
  output logic       bc_read,
  output logic       bc_write,
  output logic       bc_ack_in,
  output logic [7:0] bc_din,
  input  logic       bc_cmd_ack,
  input  logic       bc_ack_out,
  input  logic [7:0] bc_dout
);

  state_t             r_state, w_state;
  bc_cmd_t            r_cmd, w_cmd, w_load;
  logic               r_rw, w_rw;
  logic [BYTE_W-1:0]  r_adr, w_adr;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_flag, w_flag;
  logic               r_pend, w_pend;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               r_take, w_take;
  logic               r_rvld, w_rvld;
  logic [BYTE_W-1:0]  r_rdat, w_rdat;
  logic               w_last, w_fin, w_fin_err;

  assign w_last = (r_cnt == CNT_W'(0));

  // Command each state issues once the previous one has been retired
  always_comb begin
    w_load = '0;
    case (r_state)
      ST_SADR_W: w_load = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {SLAVE_ADR, 1'b0});
      ST_MADR:   w_load = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r_adr);
      ST_WDATA:  w_load = mk_cmd(1'b0, w_last, 1'b0, 1'b1, 1'b0, wdat);
      ST_SADR_R: w_load = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {SLAVE_ADR, 1'b1});
      ST_RDATA:  w_load = mk_cmd(1'b0, w_last, 1'b1, 1'b0, w_last, 8'h00);
      ST_STOP:   w_load = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      default:   w_load = '0;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_cmd     = r_cmd;
    w_rw      = r_rw;
    w_adr     = r_adr;
    w_cnt     = r_cnt;
    w_flag    = r_flag;
    w_pend    = r_pend;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_take    = 1'b0;
    w_rvld    = 1'b0;
    w_rdat    = r_rdat;
    w_fin     = 1'b0;
    w_fin_err = r_flag;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_rw    = rw;
          w_adr   = mem_adr;
          w_cnt   = len;
          w_state = ST_SADR_W;
          w_cmd   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {SLAVE_ADR, 1'b0});
          w_pend  = 1'b1;
          w_busy  = 1'b1;
        end
      end
      ST_FIN: w_state = ST_IDLE;
      default: begin
        // Idle gap between commands; after a take pulse wait one more cycle
        // so the source has presented its next byte.
        if (!r_pend) begin
          if (!r_take) begin
            w_cmd  = w_load;
            w_pend = 1'b1;
          end
        end else if (bc_cmd_ack) begin
          w_cmd  = '0;
          w_pend = 1'b0;
          if (r_state == ST_WDATA) w_take = 1'b1;
          if (r_cmd.write && bc_ack_out) begin
            if (r_cmd.stop) begin
              w_fin     = 1'b1;
              w_fin_err = 1'b1;
            end else begin
              w_flag  = 1'b1;
              w_state = ST_STOP;
            end
          end else begin
            case (r_state)
              ST_SADR_W: w_state = ST_MADR;
              ST_MADR:   w_state = r_rw ? ST_SADR_R : ST_WDATA;
              ST_SADR_R: w_state = ST_RDATA;
              ST_WDATA: begin
                if (w_last) w_fin = 1'b1;
                else        w_cnt = r_cnt - CNT_W'(1);
              end
              ST_RDATA: begin
                w_rdat = bc_dout;
                w_rvld = 1'b1;
                if (w_last) w_fin = 1'b1;
                else        w_cnt = r_cnt - CNT_W'(1);
              end
              ST_STOP:  w_fin = 1'b1;
              default:  w_state = r_state;
            endcase
          end
        end
      end
    endcase

    if (w_fin) begin
      w_state = ST_FIN;
      w_done  = 1'b1;
      w_err   = w_fin_err;
      w_busy  = 1'b0;
      w_flag  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_rw    <= 1'b0;
      r_adr   <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_take  <= 1'b0;
      r_rvld  <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state;
      r_cmd   <= w_cmd;
      r_rw    <= w_rw;
      r_adr   <= w_adr;
      r_cnt   <= w_cnt;
      r_flag  <= w_flag;
      r_pend  <= w_pend;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_take  <= w_take;
      r_rvld  <= w_rvld;
      r_rdat  <= w_rdat;
    end
  end

  assign bc_start  = r_cmd.start;
  assign bc_stop   = r_cmd.stop;
  assign bc_read   = r_cmd.read;
  assign bc_write  = r_cmd.write;
  assign bc_ack_in = r_cmd.ack_in;
  assign bc_din    = r_cmd.din;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign wdat_take = r_take;
  assign rdat_vld  = r_rvld;
  assign rdat      = r_rdat;

endmodule

// File: tb/tb_i2c_mem_seq.sv
// Bench for i2c_mem_seq: byte-controller + 32-byte slave memory model, and a
// transaction-level reference memory that predicts every transfer's outcome.
module tb_i2c_mem_seq;

  logic       clk = 1'b0;
  logic       nReset, req, rw;
  logic [7:0] mem_adr;
  logic [1:0] len;
  logic [7:0] wdat;
  logic       wdat_take, rdat_vld, busy, done, err;
  logic [7:0] rdat;
  logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack, bc_ack_out;
  logic [7:0] bc_dout;

  always #5 clk = ~clk;

  i2c_mem_seq #(.SLAVE_ADR(7'h10)) dut (
    .clk(clk), .nReset(nReset), .req(req), .rw(rw), .mem_adr(mem_adr),
    .len(len), .wdat(wdat), .wdat_take(wdat_take), .rdat(rdat),
    .rdat_vld(rdat_vld), .busy(busy), .done(done), .err(err),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read),
    .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
    .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout)
  );

  typedef struct packed {
    logic        rw;
    logic [7:0]  adr;
    logic [1:0]  len;
    logic [6:0]  resp;
    logic [31:0] wd;
    logic        exp_err;
  } vec_t;

  localparam int SL_NONE = 0, SL_ADDR = 1, SL_PTR = 2, SL_DATA = 3, SL_RD = 4;

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  sl_mem  [32];
  logic [7:0]  exp_mem [32];
  logic [6:0]  resp_adr = 7'h10;
  int          sl_st, sl_ptr;
  int          stop_only, proto_err, take_cnt, done_cnt;
  logic        last_err;
  logic        rst_abort = 1'b0;
  logic [1:0]  rd_log [$];
  logic [7:0]  rq [$];
  logic [31:0] cur_wd;
  int          m_takes, m_stop;
  logic        m_err;
  logic [7:0]  m_rd [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave behaviour for one completed byte-controller command
  task automatic do_cmd(input logic [12:0] c);
    logic s, p, r, w, ai;
    logic [7:0] din;
    {s, p, r, w, ai, din} = c;
    bc_ack_out = 1'b0;
    if (s) sl_st = SL_ADDR;
    if (w) begin
      case (sl_st)
        SL_ADDR: if (din[7:1] == resp_adr) sl_st = din[0] ? SL_RD : SL_PTR;
                 else begin bc_ack_out = 1'b1; sl_st = SL_NONE; end
        SL_PTR:  if (din < 8'd32) begin sl_ptr = int'(din); sl_st = SL_DATA; end
                 else begin bc_ack_out = 1'b1; sl_st = SL_NONE; end
        SL_DATA: if (sl_ptr < 32) begin sl_mem[sl_ptr[4:0]] = din; sl_ptr++; end
                 else bc_ack_out = 1'b1;
        default: bc_ack_out = 1'b1;
      endcase
    end
    if (r) begin
      bc_dout = (sl_st == SL_RD && sl_ptr < 32) ? sl_mem[sl_ptr[4:0]] : 8'hFF;
      sl_ptr++;
      rd_log.push_back({p, ai});
    end
    if (p) begin
      if (!r && !w) stop_only++;
      sl_st = SL_NONE;
    end
  endtask

  // Byte controller: random latency, checks command stability and gaps
  initial begin
    int bm, dly;
    logic [12:0] snap, now;
    logic active;
    bm = 0; dly = 0; snap = '0;
    bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00;
    sl_st = SL_NONE; sl_ptr = 0;
    forever begin
      @(negedge clk);
      bc_cmd_ack = 1'b0;
      now = {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
      active = (nReset === 1'b1) && ((bc_start | bc_stop | bc_read | bc_write) === 1'b1);
      if (bm == 2) begin
        if (active) proto_err++;
        else bm = 0;
      end else if (bm == 1) begin
        if (!active) begin
          if (!rst_abort) proto_err++;
          bm = 0;
        end else if (now !== snap) begin
          proto_err++;
          snap = now;
        end else if (dly == 0) begin
          do_cmd(snap);
          bc_cmd_ack = 1'b1;
          bm = 2;
        end else dly--;
      end else if (active) begin
        snap = now;
        dly = $urandom_range(0, 3);
        bm = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        bc_cmd_ack = 1'b1;
        bc_ack_out = 1'($urandom_range(0, 1));
        bc_dout = 8'($urandom);
      end
    end
  end

  // Output monitor and write-data source
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; last_err = err; end
      if (wdat_take === 1'b1) take_cnt++;
      if (rdat_vld === 1'b1) rq.push_back(rdat);
      idx = (take_cnt > 3) ? 3 : take_cnt;
      wdat = cur_wd[8*idx +: 8];
    end
  end

  // Transaction-level prediction of one request
  task automatic model(input vec_t v);
    int n, a;
    n = int'(v.len) + 1;
    m_err = 1'b0; m_takes = 0; m_stop = 0; m_rd.delete();
    if (v.resp != 7'h10 || v.adr >= 8'd32) begin
      m_err = 1'b1; m_stop = 1;
    end else if (!v.rw) begin
      for (int i = 0; i < n; i++) begin
        a = int'(v.adr) + i;
        m_takes++;
        if (a < 32) exp_mem[a[4:0]] = v.wd[8*i +: 8];
        else begin m_err = 1'b1; m_stop = (i != n-1) ? 1 : 0; break; end
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        a = int'(v.adr) + i;
        m_rd.push_back((a < 32) ? exp_mem[a[4:0]] : 8'hFF);
      end
    end
  endtask

  task automatic run_trans(input vec_t v, input logic spam, input logic use_tbl);
    int busy_hi, mism;
    logic got, exp_e;
    logic [1:0] exp_rl;
    model(v);
    exp_e = use_tbl ? v.exp_err : m_err;
    resp_adr = v.resp; cur_wd = v.wd;
    take_cnt = 0; done_cnt = 0; stop_only = 0;
    rq.delete(); rd_log.delete();
    @(negedge clk);
    req = 1'b1; rw = v.rw; mem_adr = v.adr; len = v.len;
    @(negedge clk);
    req = 1'b0;
    check("busy_start", busy, 1);
    if (spam) begin rw = ~v.rw; mem_adr = 8'h20; len = ~v.len; end
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      if (spam) req = (c % 3 == 0);
      @(negedge clk);
    end
    check("done_seen", got, 1);
    req = spam;
    @(negedge clk);
    req = 1'b0;
    busy_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    check("done_count", done_cnt, 1);
    check("err", last_err, exp_e);
    check("wdat_take_count", take_cnt, m_takes);
    check("stop_only_count", stop_only, m_stop);
    check("busy_after_done", busy_hi, 0);
    check("rdat_count", rq.size(), m_rd.size());
    for (int i = 0; i < rq.size() && i < m_rd.size(); i++) check("rdat", rq[i], m_rd[i]);
    check("read_cmd_count", rd_log.size(), m_rd.size());
    for (int i = 0; i < rd_log.size(); i++) begin
      exp_rl = (i == m_rd.size() - 1) ? 2'b11 : 2'b00;
      check("read_stop_ackin", rd_log[i], exp_rl);
    end
    mism = 0;
    for (int i = 0; i < 32; i++) if (sl_mem[i] !== exp_mem[i]) mism++;
    check("slave_mem", mism, 0);
    check("protocol", proto_err, 0);
  endtask

  initial begin
    vec_t tbl [11];
    vec_t v;
    logic got;
    nReset = 1'b0; req = 1'b0; rw = 1'b0; mem_adr = 8'h00; len = 2'd0;
    cur_wd = '0; stop_only = 0; proto_err = 0; take_cnt = 0; done_cnt = 0; last_err = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sl_mem[i]  = 8'(i * 37 + 11);
      exp_mem[i] = 8'(i * 37 + 11);
    end
    //          rw    adr    len   resp   wdata (byte0 in LSBs)  err
    tbl[0]  = {1'b0, 8'h01, 2'd1, 7'h10, 32'h0000_5AA5, 1'b0};
    tbl[1]  = {1'b1, 8'h01, 2'd1, 7'h10, 32'h0000_0000, 1'b0};
    tbl[2]  = {1'b0, 8'h01, 2'd0, 7'h12, 32'h0000_0077, 1'b1};
    tbl[3]  = {1'b0, 8'h20, 2'd0, 7'h10, 32'h0000_0099, 1'b1};
    tbl[4]  = {1'b0, 8'h1F, 2'd1, 7'h10, 32'h0000_2211, 1'b1};
    tbl[5]  = {1'b0, 8'h1E, 2'd3, 7'h10, 32'h6655_4433, 1'b1};
    tbl[6]  = {1'b1, 8'h1C, 2'd3, 7'h10, 32'h0000_0000, 1'b0};
    tbl[7]  = {1'b0, 8'h08, 2'd3, 7'h10, 32'hEFBE_ADDE, 1'b0};
    tbl[8]  = {1'b1, 8'h08, 2'd3, 7'h10, 32'h0000_0000, 1'b0};
    tbl[9]  = {1'b1, 8'h20, 2'd0, 7'h10, 32'h0000_0000, 1'b1};
    tbl[10] = {1'b1, 8'h05, 2'd0, 7'h12, 32'h0000_0000, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, err, wdat_take, rdat_vld, bc_start, bc_stop,
                         bc_read, bc_write, bc_ack_in}, 0);
    check("reset_rdat", rdat, 0);
    check("reset_bc_din", bc_din, 0);
    nReset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_trans(tbl[i], 1'b0, 1'b1);
      if (i == 0) begin
        check("mem1_a5", sl_mem[1], 8'hA5);
        check("mem2_5a", sl_mem[2], 8'h5A);
      end
      if (i == 1 && rq.size() == 2) begin
        check("read0_a5", rq[0], 8'hA5);
        check("read1_5a", rq[1], 8'h5A);
      end
    end

    // Requests while busy and during the done cycle must be dropped
    run_trans({1'b0, 8'h10, 2'd2, 7'h10, 32'h00C3_B2A1, 1'b0}, 1'b1, 1'b0);

    // Reset in the middle of a read aborts silently
    v = {1'b1, 8'h08, 2'd3, 7'h10, 32'h0, 1'b0};
    resp_adr = 7'h10; done_cnt = 0;
    @(negedge clk);
    req = 1'b1; rw = 1'b1; mem_adr = 8'h08; len = 2'd3;
    @(negedge clk);
    req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (bc_read === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("rdata_reached", got, 1);
    rst_abort = 1'b1;
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_bc_cmd", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in}, 0);
    check("abort_bc_din", bc_din, 0);
    check("abort_rdat", rdat, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    rst_abort = 1'b0;
    run_trans(v, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v = {1'($urandom), 8'($urandom_range(0, 39)), 2'($urandom),
           ($urandom_range(0, 7) == 0) ? 7'h12 : 7'h10, 32'($urandom), 1'b0};
      run_trans(v, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_mem_seq.md
I2C_MEM_SEQ -- requirements
Module: i2c_mem_seq

Interface
REQ-001 Parameter SLAVE_ADR, default 7'b001_0000, 7-bit target slave address.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 nReset  in  1  reset, synchronous and active-low.
REQ-004 req  in  1  transaction request; sampled only while busy=0.
REQ-005 rw  in  1  1=read, 0=write; captured with req.
REQ-006 mem_adr  in  8  slave memory start address; captured with req.
REQ-007 len  in  2  byte count minus one (1..4 bytes); captured with req.
REQ-008 wdat  in  8  write data byte; must be valid while busy=1 and rw=0.
REQ-009 wdat_take  out  1  one-cycle pulse: current wdat has been consumed; source presents the next byte.
REQ-010 rdat  out  8  read data byte; valid when rdat_vld=1.
REQ-011 rdat_vld  out  1  one-cycle pulse per received byte.
REQ-012 busy  out  1  high from the cycle after req acceptance until done.
REQ-013 done  out  1  one-cycle pulse at transaction end.
REQ-014 err  out  1  valid with done; 1=slave NACK aborted the transfer.
REQ-015 bc_start, bc_stop, bc_read, bc_write  out  1 each  byte-controller command bits.
REQ-016 bc_ack_in  out  1  ACK bit the master sends after a read (1=NACK).
REQ-017 bc_din  out  8  byte to transmit.
REQ-018 bc_cmd_ack  in  1  byte controller: command complete (one-cycle pulse).
REQ-019 bc_ack_out  in  1  ACK received from slave (1=NACK); valid with bc_cmd_ack.
REQ-020 bc_dout  in  8  received byte; valid with bc_cmd_ack.

Function
REQ-021 States: IDLE, SADR_W, MADR, WDATA, SADR_R, RDATA, STOP, FIN.
REQ-022 IDLE: req=1 latches rw/mem_adr/len, loads byte counter with len, goes to SADR_W; the command appears on the next cycle.
REQ-023 A command (bit set plus bc_din/bc_ack_in) is held stable until bc_cmd_ack; all bc_* command bits go low the cycle after bc_cmd_ack, for at least one cycle before the next command.
REQ-024 SADR_W: start+write, bc_din={SLAVE_ADR,0}; then MADR.
REQ-025 MADR: write, bc_din=mem_adr; then WDATA if rw=0, else SADR_R.
REQ-026 WDATA: write bc_din=wdat; wdat_take pulses with bc_cmd_ack; stop is set with the last byte (counter=0); counter decrements per byte; after the last byte go to FIN.
REQ-027 SADR_R: start+write, bc_din={SLAVE_ADR,1} (repeated start); then RDATA.
REQ-028 RDATA: read; bc_ack_in=0 except last byte bc_ack_in=1 with stop; on bc_cmd_ack rdat<=bc_dout and rdat_vld pulses; after last byte go to FIN.
REQ-029 After any write command (SADR_W, MADR, WDATA, SADR_R), bc_ack_out=1 sets the err flag and goes to STOP, except when that command already carried stop (then FIN).
REQ-030 STOP: stop-only command (no read/write); on bc_cmd_ack go to FIN.
REQ-031 FIN: done=1 and err=flag for one cycle, busy=0, flag cleared; then IDLE.
REQ-032 req while busy=1 or in FIN is ignored, with no queuing.
REQ-033 A NACK on the last write byte (stop already issued) still reports err=1 with no extra STOP.
REQ-034 bc_cmd_ack while no command is pending is ignored.
REQ-035 Counter is 2 bits and never wraps: the last-byte decision uses counter=0 before decrement.

Reset
REQ-036 nReset=0 at a clock edge: state=IDLE; busy, done, err, flag, wdat_take, rdat_vld and all bc_* command bits =0; bc_ack_in=0; rdat=0, bc_din=0, counter=0.
REQ-037 Reset mid-transaction aborts without issuing stop; no done pulse is produced.

Structure
REQ-038 Package i2c_seq_pkg holds the state encoding and the SLAVE_ADR default constant.
REQ-039 Single module with no sub-module; the byte controller is instantiated alongside it by the integrator, not inside.

Verification
REQ-040 Write rw=0, mem_adr=0x01, len=1, wdat 0xA5 then 0x5A, with the slave model at 0x10 -> two wdat_take pulses; done with err=0; slave mem[1]=0xA5, mem[2]=0x5A.
REQ-041 Read rw=1, mem_adr=0x01, len=1 after the write test -> rdat_vld pulses with 0xA5 then 0x5A; last byte sent with bc_ack_in=1 and stop; err=0.
REQ-042 SLAVE_ADR=0x11 (no responder) -> NACK on SADR_W; stop-only command; done with err=1; no wdat_take.
REQ-043 Write mem_adr=0x20 -> slave NACKs MADR; STOP; err=1.
REQ-044 req pulsed while busy=1 -> ignored; exactly one done.
REQ-045 nReset low during RDATA -> next cycle busy=0, bc_* =0, no done; a new req then completes normally.
